otp_backdoor_mem: RTL and testbench

//  Single-port block-RAM store behind the FPGA OTP emulation wrapper's backing-RAM port.
//  - Serves the wrapper with absolute priority and no stall.
//  - Gives the FPGA host a word read/write backdoor, so OTP images can be preloaded and inspected.
//  - Provides a sweep engine that blanks the whole array to all-zero (unprogrammed OTP).

---
 rtl/otp_backdoor_mem.sv | 213 +++++++++++++++++++++
 tb/tb_otp_backdoor_mem.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_backdoor_mem.sv
// otp_backdoor_mem
// Single-port word store behind the OTP emulation wrapper's backing-RAM port.
// The wrapper port always wins the array. The FPGA host gets a word read/write
// backdoor in idle cycles. A sweep engine blanks every word to zero.
// Array contents are never touched by reset.
// Optional feature macro: OTP_BACKDOOR_MEM_PARITY_EN adds a parity bit per word
// and a sticky read-parity error flag.
module otp_backdoor_mem #(
    parameter int  Width       = 16,
    parameter int  Depth       = 1024,
    parameter      MemInitFile = "",
    localparam int AddrWidth   = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 otp_mem_en_i,
    input  logic                 otp_mem_we_i,
    input  logic [AddrWidth-1:0] otp_mem_addr_i,
    input  logic [Width-1:0]     otp_mem_wdata_i,
    output logic [Width-1:0]     otp_mem_rdata_o,
    input  logic                 host_req_i,
    input  logic                 host_we_i,
    input  logic [AddrWidth-1:0] host_addr_i,
    input  logic [Width-1:0]     host_wdata_i,
    output logic                 host_gnt_o,
    output logic                 host_rvalid_o,
    output logic [Width-1:0]     host_rdata_o,
    input  logic                 clear_start_i,
    output logic                 clear_busy_o,
    output logic                 clear_done_o,
    output logic                 parity_err_o
);

`ifdef OTP_BACKDOOR_MEM_PARITY_EN
    localparam int MemW = Width + 1;
`else
    localparam int MemW = Width;
`endif

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLEAR    = 2'd1;
    localparam logic [1:0] ST_HOST_RSP = 2'd2;

    localparam logic [AddrWidth:0]   DepthExt = (AddrWidth + 1)'(Depth);
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    // Stored word: data, plus its parity in the top bit when parity is enabled.
    function automatic logic [MemW-1:0] f_encode(input logic [Width-1:0] d);
`ifdef OTP_BACKDOOR_MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    logic [MemW-1:0]      r_mem [Depth];
    logic [1:0]           r_state;
    logic [AddrWidth-1:0] r_ptr;
    logic                 r_clr_pend;
    logic                 r_clr_done;
    logic                 r_host_rvalid;
    logic [Width-1:0]     r_otp_rdata;
    logic [Width-1:0]     r_host_rdata;

    logic                 w_otp_wr;
    logic                 w_otp_rd;
    logic                 w_clr_wr;
    logic                 w_clr_go;
    logic                 w_host_gnt;
    logic                 w_host_wr;
    logic                 w_host_rd;
    logic                 w_host_in_range;
    logic                 w_mem_we;
    logic [AddrWidth-1:0] w_mem_addr;
    logic [MemW-1:0]      w_mem_wdata;
    logic [AddrWidth-1:0] w_rd_addr;
    logic [MemW-1:0]      w_rd_word;

    assign w_otp_wr        = otp_mem_en_i & otp_mem_we_i;
    assign w_otp_rd        = otp_mem_en_i & ~otp_mem_we_i;
    assign w_clr_wr        = (r_state == ST_CLEAR) & ~otp_mem_en_i;
    // A pending or fresh sweep start outranks a host request in the same idle cycle.
    assign w_clr_go        = (r_state == ST_IDLE) & (clear_start_i | r_clr_pend);
    assign w_host_gnt      = host_req_i & ~otp_mem_en_i & (r_state == ST_IDLE) & ~w_clr_go & ~rst_i;
    assign w_host_wr       = w_host_gnt & host_we_i;
    assign w_host_rd       = w_host_gnt & ~host_we_i;
    assign w_host_in_range = ({1'b0, host_addr_i} < DepthExt);
    assign w_rd_addr       = w_otp_rd ? otp_mem_addr_i : host_addr_i;
    assign w_rd_word       = r_mem[w_rd_addr];

    // Select the single array write of this cycle: wrapper, then sweep, then host.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = otp_mem_addr_i;
        w_mem_wdata = f_encode(otp_mem_wdata_i);
        if (w_otp_wr) begin
            w_mem_we = 1'b1;
        end else if (w_clr_wr) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_ptr;
            w_mem_wdata = f_encode('0);
        end else if (w_host_wr && w_host_in_range) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = host_addr_i;
            w_mem_wdata = f_encode(host_wdata_i);
        end
    end

    // Array write port; contents deliberately have no reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered read data for the wrapper and host; each holds until its next read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_otp_rdata   <= '0;
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_host_rvalid <= w_host_rd;
            if (w_otp_rd) begin
                r_otp_rdata <= w_rd_word[Width-1:0];
            end
            if (w_host_rd) begin
                r_host_rdata <= w_host_in_range ? w_rd_word[Width-1:0] : '0;
            end
        end
    end

    // Control FSM and sweep pointer; the pointer advances only on cycles the sweep owns the array.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_clr_pend <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_clr_go) begin
                        r_state    <= ST_CLEAR;
                        r_clr_pend <= 1'b0;
                    end else if (w_host_rd) begin
                        r_state <= ST_HOST_RSP;
                    end
                end
                ST_HOST_RSP: begin
                    r_state <= ST_IDLE;
                    if (clear_start_i) begin
                        r_clr_pend <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_wr) begin
                        if (r_ptr == LastAddr) begin
                            r_ptr      <= '0;
                            r_state    <= ST_IDLE;
                            r_clr_done <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef OTP_BACKDOOR_MEM_PARITY_EN
    logic             r_chk_vld;
    logic             r_chk_otp;
    logic             r_chk_pbit;
    logic             r_parity_err;
    logic [Width-1:0] w_chk_data;

    assign w_chk_data = r_chk_otp ? r_otp_rdata : r_host_rdata;

    // Check parity one cycle after each read against the registered data; error is sticky.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_chk_vld    <= 1'b0;
            r_chk_otp    <= 1'b0;
            r_chk_pbit   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_chk_vld  <= w_otp_rd | (w_host_rd & w_host_in_range);
            r_chk_otp  <= w_otp_rd;
            r_chk_pbit <= w_rd_word[Width];
            if (r_chk_vld && ((^w_chk_data) != r_chk_pbit)) begin
                r_parity_err <= 1'b1;
            end
        end
    end

    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

    assign otp_mem_rdata_o = r_otp_rdata;
    assign host_gnt_o      = w_host_gnt;
    assign host_rvalid_o   = r_host_rvalid;
    assign host_rdata_o    = r_host_rdata;
    assign clear_busy_o    = (r_state == ST_CLEAR);
    assign clear_done_o    = r_clr_done;

endmodule

// File: tb/tb_otp_backdoor_mem.sv
// Directed testbench for otp_backdoor_mem (Width=16, Depth=1024).
module tb_otp_backdoor_mem;

    localparam int W  = 16;
    localparam int D  = 1024;
    localparam int AW = 10;

`ifdef OTP_BACKDOOR_MEM_PARITY_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          otp_en, otp_we;
    logic [AW-1:0] otp_addr;
    logic [W-1:0]  otp_wdata, otp_rdata;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [W-1:0]  host_wdata, host_rdata;
    logic          host_gnt, host_rvalid;
    logic          clear_start, clear_busy, clear_done, parity_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otp_backdoor_mem #(.Width(W), .Depth(D)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .otp_mem_en_i    (otp_en),
        .otp_mem_we_i    (otp_we),
        .otp_mem_addr_i  (otp_addr),
        .otp_mem_wdata_i (otp_wdata),
        .otp_mem_rdata_o (otp_rdata),
        .host_req_i      (host_req),
        .host_we_i       (host_we),
        .host_addr_i     (host_addr),
        .host_wdata_i    (host_wdata),
        .host_gnt_o      (host_gnt),
        .host_rvalid_o   (host_rvalid),
        .host_rdata_o    (host_rdata),
        .clear_start_i   (clear_start),
        .clear_busy_o    (clear_busy),
        .clear_done_o    (clear_done),
        .parity_err_o    (parity_err)
    );

    // Stimulus helpers (drive only)
    task automatic host_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        int n;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1;
        n = 0;
        while (!host_gnt && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (host_gnt !== 1'b1) begin
            errors++;
            $display("FAIL host_write_grant addr=%h got=%b want=1", a, host_gnt);
        end
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic otp_read(input logic [AW-1:0] a, output logic [W-1:0] d);
        @(negedge clk);
        otp_en = 1'b1; otp_we = 1'b0; otp_addr = a;
        @(negedge clk);
        otp_en = 1'b0;
        d = otp_rdata;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_start = 1'b1;
        @(negedge clk); clear_start = 1'b0;
    endtask

    task automatic wait_clear(output int cnt, output logic done_seen);
        cnt = 0;
        while (clear_busy && cnt < 3000) begin
            cnt++; @(negedge clk);
        end
        done_seen = clear_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        otp_en = 0; otp_we = 0; otp_addr = '0; otp_wdata = '0;
        host_req = 1'b1; host_we = 0; host_addr = '0; host_wdata = '0;
        clear_start = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (host_gnt !== 1'b0)     begin errors++; $display("FAIL reset_gnt got=%b want=0", host_gnt); end
        checks++; if (host_rvalid !== 1'b0)  begin errors++; $display("FAIL reset_rvalid got=%b want=0", host_rvalid); end
        checks++; if (host_rdata !== 16'h0)  begin errors++; $display("FAIL reset_host_rdata got=%h want=0000", host_rdata); end
        checks++; if (otp_rdata !== 16'h0)   begin errors++; $display("FAIL reset_otp_rdata got=%h want=0000", otp_rdata); end
        checks++; if (clear_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", clear_busy); end
        checks++; if (clear_done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b want=0", clear_done); end
        checks++; if (parity_err !== 1'b0)   begin errors++; $display("FAIL reset_parity got=%b want=0", parity_err); end
        host_req = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_host_write_otp_read();
        logic [W-1:0] d;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h010; host_wdata = 16'h00A5;
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL hw_gnt_same_cycle got=%b want=1", host_gnt); end
        @(negedge clk);
        host_req = 1'b0; host_we = 1'b0;
        otp_read(10'h010, d);
        checks++; if (d !== 16'h00A5) begin errors++; $display("FAIL otp_read_0x010 got=%h want=00a5", d); end
    endtask

    task automatic test_host_read_wait();
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010;
        otp_en = 1'b1; otp_we = 1'b0; otp_addr = 10'h011;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL hr_gnt_withheld cycle=%0d got=%b want=0", i, host_gnt); end
            @(negedge clk);
        end
        otp_en = 1'b0;
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL hr_gnt_after_otp got=%b want=1", host_gnt); end
        @(negedge clk);
        #1;
        checks++; if (host_rvalid !== 1'b1)   begin errors++; $display("FAIL hr_rvalid got=%b want=1", host_rvalid); end
        checks++; if (host_rdata !== 16'h00A5) begin errors++; $display("FAIL hr_rdata got=%h want=00a5", host_rdata); end
        checks++; if (host_gnt !== 1'b0)      begin errors++; $display("FAIL hr_no_gnt_in_rsp got=%b want=0", host_gnt); end
        @(negedge clk);
        #1;
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL hr_rvalid_pulse got=%b want=0", host_rvalid); end
        checks++; if (host_gnt !== 1'b1)    begin errors++; $display("FAIL hr_second_gnt got=%b want=1", host_gnt); end
        @(negedge clk);
        host_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals [4];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            host_req = 1'b1; host_we = 1'b1; host_addr = 10'h100 + AW'(i); host_wdata = vals[i];
            #1;
            checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL b2b_write_gnt i=%0d got=%b want=1", i, host_gnt); end
        end
        @(negedge clk);
        host_req = 1'b0; host_we = 1'b0;
        otp_en = 1'b1; otp_we = 1'b0; otp_addr = 10'h100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (otp_rdata !== vals[i]) begin errors++; $display("FAIL b2b_otp_read i=%0d got=%h want=%h", i, otp_rdata, vals[i]); end
            if (i < 3) otp_addr = 10'h101 + AW'(i);
            else otp_en = 1'b0;
        end
        otp_addr = 10'h000;
        @(negedge clk);
        checks++; if (otp_rdata !== 16'h4444) begin errors++; $display("FAIL otp_rdata_hold got=%h want=4444", otp_rdata); end
    endtask

    task automatic test_otp_priority();
        @(negedge clk);
        otp_en = 1'b1; otp_we = 1'b1; otp_addr = 10'h050; otp_wdata = 16'hBEEF;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h050;
        #1;
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL prio_gnt_blocked got=%b want=0", host_gnt); end
        @(negedge clk);
        otp_en = 1'b0; otp_we = 1'b0;
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL prio_gnt_retry got=%b want=1", host_gnt); end
        @(negedge clk);
        host_req = 1'b0;
        checks++; if (host_rdata !== 16'hBEEF || host_rvalid !== 1'b1) begin
            errors++; $display("FAIL prio_read_new_data got=%h/%b want=beef/1", host_rdata, host_rvalid);
        end
    endtask

    task automatic test_clear_idle();
        int cnt; logic dn; logic [W-1:0] d;
        logic [AW-1:0] addrs [4];
        host_write(10'h3FF, 16'h7777);
        pulse_clear();
        wait_clear(cnt, dn);
        checks++; if (cnt != 1024) begin errors++; $display("FAIL clear_busy_cycles got=%0d want=1024", cnt); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL clear_done_pulse got=%b want=1", dn); end
        @(negedge clk);
        checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL clear_done_one_cycle got=%b want=0", clear_done); end
        addrs[0] = 10'h000; addrs[1] = 10'h010; addrs[2] = 10'h100; addrs[3] = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            otp_read(addrs[i], d);
            checks++; if (d !== 16'h0000) begin errors++; $display("FAIL clear_word addr=%h got=%h want=0000", addrs[i], d); end
        end
    endtask

    task automatic test_clear_with_otp();
        int cnt; logic [W-1:0] d;
        host_write(10'h300, 16'h1357);
        pulse_clear();
        cnt = 0;
        while (clear_busy && cnt < 3000) begin
            otp_en = 1'b0; otp_we = 1'b0; clear_start = 1'b0;
            if (cnt == 100) begin otp_en = 1'b1; otp_we = 1'b1; otp_addr = 10'h020; otp_wdata = 16'hCAFE; end
            else if (cnt == 101) begin otp_en = 1'b1; otp_we = 1'b1; otp_addr = 10'h300; otp_wdata = 16'hDEAD; end
            else if (cnt >= 102 && cnt <= 109) begin otp_en = 1'b1; otp_addr = 10'h000; end
            else if (cnt == 110) clear_start = 1'b1;
            cnt++;
            @(negedge clk);
        end
        otp_en = 1'b0; otp_we = 1'b0; clear_start = 1'b0;
        checks++; if (cnt != 1034) begin errors++; $display("FAIL paused_busy_cycles got=%0d want=1034", cnt); end
        checks++; if (clear_done !== 1'b1) begin errors++; $display("FAIL paused_done got=%b want=1", clear_done); end
        @(negedge clk);
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL paused_no_restart got=%b want=0", clear_busy); end
        otp_read(10'h020, d);
        checks++; if (d !== 16'hCAFE) begin errors++; $display("FAIL swept_then_written got=%h want=cafe", d); end
        otp_read(10'h300, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL written_then_swept got=%h want=0000", d); end
        otp_read(10'h064, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL pause_boundary_word got=%h want=0000", d); end
    endtask

    task automatic test_clear_after_host_rsp();
        int cnt; logic dn; logic [W-1:0] d;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h020;
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL rsp_gnt got=%b want=1", host_gnt); end
        @(negedge clk);
        host_req = 1'b0; clear_start = 1'b1;
        checks++; if (host_rdata !== 16'hCAFE) begin errors++; $display("FAIL rsp_rdata got=%h want=cafe", host_rdata); end
        @(negedge clk);
        clear_start = 1'b0;
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rsp_busy_latched got=%b want=0", clear_busy); end
        @(negedge clk);
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL rsp_clear_entered got=%b want=1", clear_busy); end
        wait_clear(cnt, dn);
        checks++; if (cnt != 1024 || dn !== 1'b1) begin errors++; $display("FAIL rsp_clear_run got=%0d/%b want=1024/1", cnt, dn); end
        otp_read(10'h020, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rsp_clear_word got=%h want=0000", d); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [W-1:0] d;
        host_write(10'h1FF, 16'h1111);
        host_write(10'h200, 16'h5A5A);
        host_write(10'h3FE, 16'h0F0F);
        pulse_clear();
        repeat (512) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", clear_busy); end
        checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b want=0", clear_done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_stay_idle got=%b want=0", clear_busy); end
        otp_read(10'h1FF, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_mid_swept got=%h want=0000", d); end
        otp_read(10'h200, d);
        checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL rst_mid_kept_200 got=%h want=5a5a", d); end
        otp_read(10'h3FE, d);
        checks++; if (d !== 16'h0F0F) begin errors++; $display("FAIL rst_mid_kept_3fe got=%h want=0f0f", d); end
    endtask

    task automatic test_parity();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean got=%b want=0", parity_err); end
        dut.r_mem[32][0] = ~dut.r_mem[32][0];
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h020;
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL parity_gnt got=%b want=1", host_gnt); end
        @(negedge clk);
        host_req = 1'b0;
        checks++; if (host_rdata !== 16'h0001) begin errors++; $display("FAIL parity_data_unmodified got=%h want=0001", host_rdata); end
        @(negedge clk);
        checks++; if (parity_err !== PAR_EXP) begin errors++; $display("FAIL parity_flag got=%b want=%b", parity_err, PAR_EXP); end
        repeat (3) @(negedge clk);
        checks++; if (parity_err !== PAR_EXP) begin errors++; $display("FAIL parity_sticky got=%b want=%b", parity_err, PAR_EXP); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_reset got=%b want=0", parity_err); end
    endtask

    initial begin
        test_reset();
        test_host_write_otp_read();
        test_host_read_wait();
        test_back_to_back();
        test_otp_priority();
        test_clear_idle();
        test_clear_with_otp();
        test_clear_after_host_rsp();
        test_reset_mid_sweep();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
